// File: rtl/brent_kung_adder32.sv
// 32-bit adder with a Brent-Kung parallel-prefix carry network and a registered
// sum/carry-out; one result per cycle with one cycle of latency.
module brent_kung_adder32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_grp;
  // Group propagate is never needed for bit 0 since the carry-in is zero
  logic [WIDTH-1:1] p_grp;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  assign g = a & b;
  assign p = a ^ b;

  // Prefix tree evaluated in place: each level only overwrites nodes whose
  // partner node at that level is left untouched.
  always_comb begin
    g_grp = g;
    p_grp = p[WIDTH-1:1];
    // Up-sweep: nodes whose span reaches bit 0 only need a gray cell
    for (int k = 1; k <= int'(LEVELS); k++) begin
      for (int i = 1; i < int'(WIDTH); i++) begin
        if (((i + 1) % (1 << k)) == 0) begin
          if ((i + 1) == (1 << k)) begin
            g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i - (1 << (k - 1))]);
          end else begin
            g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i - (1 << (k - 1))]);
            p_grp[i] = p_grp[i] & p_grp[i - (1 << (k - 1))];
          end
        end
      end
    end
    // Down-sweep: the lower partner is already complete, so gray cells only
    for (int k = int'(LEVELS) - 1; k >= 1; k--) begin
      for (int i = 1; i < int'(WIDTH); i++) begin
        if ((((i + 1) % (1 << k)) == (1 << (k - 1))) && (i >= (1 << k))) begin
          g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i - (1 << (k - 1))]);
        end
      end
    end
  end

  assign carry     = {g_grp[WIDTH-2:0], 1'b0};
  assign sum_next  = p ^ carry;
  assign cout_next = g_grp[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= cout_next;
    end
  end

endmodule

// File: tb/tb_brent_kung_adder32.sv
// Directed and random checks of brent_kung_adder32 against hand-computed and
// 33-bit reference sums, including asynchronous reset behaviour.
module tb_brent_kung_adder32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        cout;

  int n_cmp = 0;
  int n_bad = 0;

  brent_kung_adder32 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {cout,sum}=%h expected %h", tag, got, exp);
    end
  endtask

  localparam int NV = 11;
  // Last three entries form the back-to-back pipelining sequence 2, 12, 1
  logic [31:0] va [NV] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                           32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_07FF, 32'h1234_5678,
                           32'h0000_0001, 32'h0000_0005, 32'hFFFF_FFFF};
  logic [31:0] vb [NV] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001,
                           32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h9ABC_DEF0,
                           32'h0000_0001, 32'h0000_0007, 32'h0000_0002};
  logic [32:0] ve [NV] = '{33'h0_0000_0002, 33'h0_0000_0000, 33'h1_0000_0000, 33'h0_8000_0000,
                           33'h1_FFFF_FFFE, 33'h0_0001_0000, 33'h0_0000_0800, 33'h0_ACF1_3568,
                           33'h0_0000_0002, 33'h0_0000_000C, 33'h1_0000_0001};

  initial begin
    logic [32:0] exp_q;
    logic        valid_q;

    rst = 1'b1;
    a   = '0;
    b   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_init", {cout, sum}, 33'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      a = va[i];
      b = vb[i];
      @(negedge clk);
      check($sformatf("vec%0d_%h_%h", i, va[i], vb[i]), {cout, sum}, ve[i]);
    end

    // Asynchronous reset between edges with all-ones operands
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(negedge clk);
    check("pre_rst", {cout, sum}, 33'h1_FFFF_FFFE);
    #2 rst = 1'b1;
    #1 check("rst_async", {cout, sum}, 33'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold", {cout, sum}, 33'h0);
    rst = 1'b0;
    a   = 32'h0000_0003;
    b   = 32'h0000_0004;
    @(negedge clk);
    check("post_rst", {cout, sum}, 33'h0_0000_0007);

    // Random operands with occasional reset pulses
    valid_q = 1'b0;
    exp_q   = '0;
    for (int n = 0; n < 10000; n++) begin
      if (valid_q) check("random", {cout, sum}, exp_q);
      rst     = ($urandom_range(63) == 0);
      a       = $urandom;
      b       = $urandom;
      exp_q   = {1'b0, a} + {1'b0, b};
      valid_q = !rst;
      @(negedge clk);
    end
    if (valid_q) check("random", {cout, sum}, exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/brent_kung_adder32.md
# brent_kung_adder32

32-bit unsigned/two's-complement adder built on a Brent-Kung parallel-prefix carry network, with a registered result. It is the datapath adder used by arithmetic blocks that need a log-depth carry chain. The module is named `brent_kung_adder32`. Each clock it samples operands `a` and `b` and presents `sum = a + b` (mod 2^32) plus carry-out one cycle later.

## Interface
- `WIDTH`, default 32: operand/result width. Fixed at 32; the prefix tree is sized for 32 bits (5 up-sweep levels).
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset; clears all output registers immediately on assertion.
- `a`  input  32  operand A.
- `b`  input  32  operand B.
- `sum`  output  32  registered (a + b) mod 2^32.
- `cout`  output  1  registered carry out of bit 31.

One clock; reset is asynchronous and active-high.

## Operation
- Bit level:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
  - Carry-in to bit 0 is 0.
- Prefix operator: (G,P) o (G',P') = (G | P&G', P&P').
  - Implemented as explicit black cells (G and P) and gray cells (G only).
  - Carries are never derived with a behavioural `+`.
- Up-sweep, levels 1..5:
  - At level k, for every i with (i+1) mod 2^k == 0, combine node i with node i-2^(k-1).
  - This yields group generate G[i:0] at i = 1, 3, 7, 15, 31.
- Down-sweep, levels 4..1:
  - At level k, for every i with (i+1) mod 2^k == 2^(k-1) and i ≥ 2^k, combine node i with node i-2^(k-1).
  - This fills in G[i:0] for all remaining i.
- Carries:
  - c[0] = 0
  - c[i+1] = G[i:0]
- Sum: s[i] = p[i] ^ c[i].
- Carry out: cout_next = G[31:0].
- Overflow is not flagged. The result wraps modulo 2^32; signed and unsigned interpretations share the same bits.
- No enable: new operands are accepted every cycle.

## Timing
- Prefix network and sum logic are purely combinational from `a`/`b`.
- `sum` and `cout` are registered on the rising edge of `clk`.
- Latency is exactly 1 cycle: operands present before edge N appear at the outputs after edge N.
- Throughput is 1 result per cycle; back-to-back operand changes each produce an independent result.
- Reset:
  - While `rst`=1, `sum`=32'h0000_0000 and `cout`=0, regardless of clock.
  - Assertion takes effect without waiting for a clock edge.
  - The first result after deassertion is taken from operands sampled at the first rising edge with `rst`=0.
- Reset mid-stream: any in-flight result is discarded, with no partial update.
- Before the first clock after power-up without reset, outputs are undefined. Benches must apply `rst` first.
- Operand X/Z values are not supported; output for such inputs is unspecified.

## Test plan
- Reset: assert `rst` asynchronously between edges with a=b=32'hFFFF_FFFF. Required: `sum`=0 and `cout`=0 immediately, and they stay 0 across clocks while `rst`=1.
- Basic: a=32'h1, b=32'h1. Required one cycle later: `sum`=32'h2, `cout`=0. Also a=0, b=0 gives `sum`=0, `cout`=0.
- Full carry ripple:
  - a=32'hFFFF_FFFF, b=32'h1. Required: `sum`=32'h0, `cout`=1.
  - a=32'h7FFF_FFFF, b=32'h1. Required: `sum`=32'h8000_0000, `cout`=0.
- Max operands and mixed prefixes:
  - a=b=32'hFFFF_FFFF. Required: `sum`=32'hFFFF_FFFE, `cout`=1.
  - a=32'h0000_FFFF, b=32'h0000_0001. Required: `sum`=32'h0001_0000, `cout`=0. This exercises the up-sweep at bit 15.
  - a=32'h0000_07FF, b=32'h1. Required: `sum`=32'h0000_0800. This exercises the down-sweep node at bit 10.
- Pipelining: apply (1,1), (5,7), (FFFF_FFFF,2) on consecutive edges. Required: `sum` sequence 2, 12, 1 with `cout` 0, 0, 1, each one cycle after its inputs.
- Random: at least 10,000 random 32-bit pairs checked against the 33-bit reference a+b, with random `rst` pulses. Results are compared only when no reset occurred in the preceding cycle.
